// File: rtl/sp_ram_pkg.sv
// Shared types and helpers for the parametrised single-port RAM.
// Holds the read-during-write mode, the clear FSM state and a byte-lane merge function.
package sp_ram_pkg;

  typedef enum logic [1:0] {
    RDW_WRITE_FIRST = 2'd0,
    RDW_READ_FIRST  = 2'd1,
    RDW_NO_CHANGE   = 2'd2
  } rdw_mode_e;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } clr_state_e;

  // Widest word byte_merge handles; callers zero-extend and truncate around it.
  localparam int MAX_DATA_W = 1024;
  localparam int MAX_BE_W   = MAX_DATA_W / 8;

  function automatic logic [MAX_DATA_W-1:0] byte_merge(
    input logic [MAX_DATA_W-1:0] old_w,
    input logic [MAX_DATA_W-1:0] new_w,
    input logic [MAX_BE_W-1:0]   be_w
  );
    logic [MAX_DATA_W-1:0] merged;
    merged = old_w;
    for (int i = 0; i < MAX_BE_W; i++) begin
      if (be_w[i]) merged[8*i +: 8] = new_w[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/sp_ram_clr_fsm.sv
// Zero-fill sweep controller: walks a pointer over every word after reset or on request.
// Busy stays high for exactly DEPTH cycles per sweep.
module sp_ram_clr_fsm
  import sp_ram_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr_req,
  output logic              o_busy,
  output logic              o_clr_we,
  output logic [ADDR_W-1:0] o_clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  clr_state_e        r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CLEAR;
      r_ptr   <= '0;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        CLEAR: begin
          // Pointer parks on the last word; only a new sweep rewinds it.
          if (r_ptr == LAST_ADDR) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_ptr <= r_ptr + 1'b1;
          end
        end
        IDLE: begin
          if (i_clr_req) begin
            r_state <= CLEAR;
            r_ptr   <= '0;
            r_busy  <= 1'b1;
          end
        end
        default: begin
          r_state <= CLEAR;
          r_ptr   <= '0;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_clr_we   = (r_state == CLEAR);
  assign o_clr_addr = r_ptr;

endmodule

// File: rtl/sp_ram_param.sv
// Parametrised single-port RAM with byte enables, selectable read-during-write and a zero-fill engine.
// Define SP_RAM_OUT_REG_EN to add a second output register (2-cycle read latency).
module sp_ram_param
  import sp_ram_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 10,
  parameter int RDW_MODE = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   data,
  input  logic [ADDR_W-1:0]   addr,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic                clr_req,
  output logic                busy,
  output logic [DATA_W-1:0]   q
);

  localparam int        BE_W  = DATA_W / 8;
  localparam int        DEPTH = 2 ** ADDR_W;
  localparam rdw_mode_e MODE  = rdw_mode_e'(RDW_MODE[1:0]);

  logic              w_busy;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_user_en;
  logic              w_user_we;
  logic [DATA_W-1:0] w_old;
  logic [DATA_W-1:0] w_merged;
  logic [DATA_W-1:0] r_q;

  sp_ram_clr_fsm #(
    .ADDR_W(ADDR_W)
  ) u_clr_fsm (
    .clk       (clk),
    .rst       (rst),
    .i_clr_req (clr_req),
    .o_busy    (w_busy),
    .o_clr_we  (w_clr_we),
    .o_clr_addr(w_clr_addr)
  );

  // A clear request in IDLE pre-empts the user access of the same cycle.
  assign w_user_en = ~w_busy & ~clr_req;
  assign w_user_we = w_user_en & we;

  // One array per byte lane keeps byte-enable writes mappable to block RAM.
  for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
    logic [7:0] r_lane [DEPTH];

    always_ff @(posedge clk) begin
      if (!rst) begin
        if (w_clr_we) begin
          r_lane[w_clr_addr] <= 8'h00;
        end else if (w_user_we && be[gi]) begin
          r_lane[addr] <= data[8*gi +: 8];
        end
      end
    end

    assign w_old[8*gi +: 8] = r_lane[addr];
  end

  assign w_merged = DATA_W'(byte_merge(MAX_DATA_W'(w_old), MAX_DATA_W'(data), MAX_BE_W'(be)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (w_user_en) begin
      if (!we) begin
        r_q <= w_old;
      end else begin
        case (MODE)
          RDW_WRITE_FIRST: r_q <= w_merged;
          RDW_READ_FIRST:  r_q <= w_old;
          default:         r_q <= r_q;
        endcase
      end
    end
  end

`ifdef SP_RAM_OUT_REG_EN
  logic [DATA_W-1:0] r_q_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q_out <= '0;
    end else if (!w_busy) begin
      r_q_out <= r_q;
    end
  end

  assign q = r_q_out;
`else
  assign q = r_q;
`endif

  assign busy = w_busy;

endmodule

// File: doc/sp_ram_param.md
Name: sp_ram_param

Overview:
- Parametrised single-port synchronous RAM; successor to the fixed 32x1024 single-port RAM.
- Generalised in data width and depth.
- Adds per-byte write enables, a selectable read-during-write mode, and a hardware clear engine that zero-fills memory after reset or on request.
- Used as the golden and fabric-mapped RAM primitive in post-route comparison benches.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- ADDR_W, 10, address width; DEPTH = 2**ADDR_W words.
- RDW_MODE, 0, read-during-write behaviour: 0 = write-first, 1 = read-first, 2 = no-change.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- data  in  DATA_W  write data.
- addr  in  ADDR_W  word address.
- we  in  1  write enable.
- be  in  DATA_W/8  byte enables; bit i qualifies data[8i+7:8i].
- clr_req  in  1  one-cycle pulse; starts a full-memory zero-fill.
- busy  out  1  high while a clear is in progress; user accesses are ignored.
- q  out  DATA_W  registered read data.

Behaviour:
- Reset (rst=1 at a clock edge):
  - q <= 0, busy <= 1, clear pointer <= 0, FSM <= CLEAR.
  - Reset takes priority over all inputs.
- FSM states:
  - CLEAR: each cycle writes 0 to mem[ptr], then ptr <= ptr+1. When ptr == DEPTH-1, the FSM goes to IDLE on the next edge, busy <= 0. A clear takes exactly DEPTH cycles.
  - IDLE: normal access. clr_req=1 forces ptr <= 0, busy <= 1, FSM <= CLEAR.
- During CLEAR:
  - we, be, data, addr and clr_req are ignored.
  - q holds its last value (0 after reset).
- Access timing in IDLE: one-cycle read latency; q reflects mem[addr] at the following edge.
- Write (we=1): mem[addr] byte i <= data byte i for each be[i]=1; other bytes are unchanged. we=1 with be=0 writes nothing, but q updates per RDW_MODE.
- Read-during-write q:
  - Mode 0: q <= the merged new word (old bytes where be=0, new bytes where be=1).
  - Mode 1: q <= the old word.
  - Mode 2: q holds its previous value.
- Read (we=0): q <= mem[addr] in all modes.
- clr_req together with we in IDLE: clr_req wins and the write is dropped.
- Address wrap: addr is exactly ADDR_W bits, so no out-of-range access exists. The clear pointer wraps to 0 only on a new clear.
- Reset mid-clear restarts the sweep from pointer 0 with a full DEPTH-cycle clear.

Optional Feature:
- Macro: SP_RAM_OUT_REG_EN.
- Defined:
  - An extra output register stage is added; read latency becomes 2 cycles.
  - The stage resets to 0 and holds during CLEAR.
  - RDW semantics are preserved, delayed by one cycle.
- Undefined: latency is 1 cycle as specified above.

Decomposition:
- Package sp_ram_pkg:
  - rdw_mode_e enum (RDW_WRITE_FIRST=0, RDW_READ_FIRST=1, RDW_NO_CHANGE=2).
  - clr_state_e enum (CLEAR, IDLE).
  - Function byte_merge(old, new, be).
- Sub-module sp_ram_clr_fsm: owns the state, pointer and busy. It outputs clear write-enable and clear address to the top-level mux. The array and q logic stay in sp_ram_param.

Test Plan (DATA_W=32, ADDR_W=10, no macro unless stated):
- Reset clear: rst 1 cycle, then release:
  - busy stays high for exactly 1024 cycles, then drops.
  - Reading addr 0, 517 and 1023 returns 0x00000000.
- Write-first (RDW_MODE=0): write 0xDEADBEEF to addr 5, be=4'hF → q=0xDEADBEEF on the next edge. A read of addr 5 also returns 0xDEADBEEF.
- Byte enable: over 0xDEADBEEF at addr 5, write 0x12345678 with be=4'b0011 → read returns 0xDEAD5678.
- Read-first (RDW_MODE=1):
  - addr 9 holds 0x11111111; write 0xA5A5A5A5 → q=0x11111111.
  - The following read gives 0xA5A5A5A5.
  - The same stimulus with RDW_MODE=2 leaves q at its prior value.
- clr_req after 32 random writes (addr 0..31):
  - busy rises the next cycle.
  - A we=1 issued during the clear is ignored.
  - After 1024 cycles, all 32 addresses read 0.
- Reset mid-clear and macro latency:
  - rst asserted at clear cycle 300 → the full 1024-cycle sweep restarts.
  - With SP_RAM_OUT_REG_EN: write 0xCAFEF00D to addr 1023 → read data appears 2 cycles after the read address.
